// File: rtl/cv32e40p_ft_status_collector.sv
// Fault-tolerance status collector: per-unit event counters, sticky flags and replica force
// register behind a 1-cycle-latency register port, with a level interrupt.

module cv32e40p_ft_status_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             det_i,
    input  logic             cor_i,
    input  logic [2:0]       brk_i,
    input  logic             wr_i,
    input  logic [1:0]       sub_i,
    input  logic [6:0]       wdata_i,
    output logic [CNT_W-1:0] det_cnt_o,
    output logic [CNT_W-1:0] cor_cnt_o,
    output logic [2:0]       newbrk_o,
    output logic             uncor_o,
    output logic [2:0]       force_o
);

    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
    logic [CNT_W-1:0] cor_cnt_q, cor_cnt_d;
    logic [2:0]       newbrk_q, newbrk_d;
    logic [2:0]       brk_prev_q;
    logic             uncor_q, uncor_d;
    logic [2:0]       force_q, force_d;

    // Clear is applied first so an event in the same cycle still lands (result 1).
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic clr, input logic inc);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (inc && (base != '1)) base = base + CNT_W'(1);
        return base;
    endfunction

    always_comb begin
        det_cnt_d = cnt_next(det_cnt_q, wr_i && (sub_i == 2'd0), det_i);
        cor_cnt_d = cnt_next(cor_cnt_q, wr_i && (sub_i == 2'd1), cor_i);
        uncor_d   = (uncor_q & ~(wr_i && (sub_i == 2'd2) && wdata_i[6])) | (det_i & ~cor_i);
        newbrk_d  = (newbrk_q & ~({3{wr_i && (sub_i == 2'd2)}} & wdata_i[5:3]))
                  | (brk_i & ~brk_prev_q);
        force_d   = (wr_i && (sub_i == 2'd3)) ? wdata_i[2:0] : force_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_cnt_q  <= '0;
            cor_cnt_q  <= '0;
            newbrk_q   <= '0;
            brk_prev_q <= '0;
            uncor_q    <= 1'b0;
            force_q    <= '0;
        end else begin
            det_cnt_q  <= det_cnt_d;
            cor_cnt_q  <= cor_cnt_d;
            newbrk_q   <= newbrk_d;
            brk_prev_q <= brk_i;
            uncor_q    <= uncor_d;
            force_q    <= force_d;
        end
    end

    assign det_cnt_o = det_cnt_q;
    assign cor_cnt_o = cor_cnt_q;
    assign newbrk_o  = newbrk_q;
    assign uncor_o   = uncor_q;
    assign force_o   = force_q;

endmodule

module cv32e40p_ft_status_collector #(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned ADDR_W = $clog2(N_UNITS) + 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_UNITS-1:0]     err_detected_i,
    input  logic [N_UNITS-1:0]     err_corrected_i,
    input  logic [3*N_UNITS-1:0]   is_broken_i,
    output logic [3*N_UNITS-1:0]   set_broken_o,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   irq_o
);

    logic [N_UNITS-1:0][CNT_W-1:0] det_cnt, cor_cnt;
    logic [N_UNITS-1:0][2:0]       newbrk, force_bits;
    logic [N_UNITS-1:0]            uncor, unit_flag;
    logic [N_UNITS-1:0]            unit_wr;
    int unsigned                   unit_sel;
    logic [1:0]                    sub;
    logic [31:0]                   rd_mux;
    logic                          rvalid_q, irq_q;
    logic [31:0]                   rdata_q;

    assign unit_sel = 32'(addr_i >> 2);
    assign sub      = addr_i[1:0];

    for (genvar u = 0; u < N_UNITS; u++) begin : g_unit
        assign unit_wr[u]   = req_i & we_i & (unit_sel == u);
        assign unit_flag[u] = uncor[u] | (|newbrk[u]);

        cv32e40p_ft_status_unit #(.CNT_W(CNT_W)) i_unit (
            .clk       (clk),
            .rst_n     (rst_n),
            .det_i     (err_detected_i[u]),
            .cor_i     (err_corrected_i[u]),
            .brk_i     (is_broken_i[3*u +: 3]),
            .wr_i      (unit_wr[u]),
            .sub_i     (sub),
            .wdata_i   (wdata_i[6:0]),
            .det_cnt_o (det_cnt[u]),
            .cor_cnt_o (cor_cnt[u]),
            .newbrk_o  (newbrk[u]),
            .uncor_o   (uncor[u]),
            .force_o   (force_bits[u])
        );

        assign set_broken_o[3*u +: 3] = force_bits[u];
    end

    // Out-of-range units match no iteration and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int unsigned u = 0; u < N_UNITS; u++) begin
            if (unit_sel == u) begin
                case (sub)
                    2'd0:    rd_mux = 32'(det_cnt[u]);
                    2'd1:    rd_mux = 32'(cor_cnt[u]);
                    2'd2:    rd_mux = {25'd0, uncor[u], newbrk[u], is_broken_i[3*u +: 3]};
                    default: rd_mux = {29'd0, force_bits[u]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= req_i & ~we_i;
            rdata_q  <= (req_i & ~we_i) ? rd_mux : '0;
            irq_q    <= |unit_flag;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_cv32e40p_ft_status_collector.sv
// Directed bench: vector table on a 4-unit/16-bit instance, hand sequences for reset
// and on a 3-unit/2-bit instance for saturation and out-of-range units.

module tb_cv32e40p_ft_status_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [3:0]  det, cor;
    logic [11:0] brk, set_b;
    logic        req, we, rv, irq;
    logic [3:0]  addr;
    logic [31:0] wdata, rd;

    logic [2:0]  s_det, s_cor;
    logic [8:0]  s_brk, s_set;
    logic        s_req, s_we, s_rv, s_irq;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata, s_rd;

    cv32e40p_ft_status_collector #(.N_UNITS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .err_detected_i(det), .err_corrected_i(cor),
        .is_broken_i(brk), .set_broken_o(set_b), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rvalid_o(rv), .rdata_o(rd), .irq_o(irq)
    );

    cv32e40p_ft_status_collector #(.N_UNITS(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .err_detected_i(s_det), .err_corrected_i(s_cor),
        .is_broken_i(s_brk), .set_broken_o(s_set), .req_i(s_req), .we_i(s_we), .addr_i(s_addr),
        .wdata_i(s_wdata), .rvalid_o(s_rv), .rdata_o(s_rd), .irq_o(s_irq)
    );

    typedef struct {
        logic        req, we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  det, cor;
        logic [11:0] brk;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic [11:0] exp_set;
    } vec_t;

    vec_t tbl [33];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rq, input logic w, input logic [3:0] a,
                                input logic [31:0] wd, input logic [3:0] d, input logic [3:0] c,
                                input logic [11:0] b, input logic erv, input logic [31:0] erd,
                                input logic eirq, input logic [11:0] eset);
        vec_t v;
        v.req = rq; v.we = w; v.addr = a; v.wdata = wd; v.det = d; v.cor = c; v.brk = b;
        v.exp_rv = erv; v.exp_rd = erd; v.exp_irq = eirq; v.exp_set = eset;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_idle();
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    endtask

    task automatic s_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        s_req = 1'b1; s_we = 1'b0; s_addr = a;
        step();
        s_idle();
        check({name, " rvalid"}, 32'(s_rv), 32'd1);
        check(name, s_rd, exp);
    endtask

    initial begin
        // main instance: {req,we,addr,wdata,det,cor,brk, exp rvalid,rdata,irq,set_broken}
        for (int i = 0; i < 5; i++) tbl[i] = mk(0,0,4'h0,0,4'h2,4'h2,12'h000, 0,0,0,12'h000);
        tbl[5]  = mk(1,0,4'h4,0,4'h0,4'h0,12'h000, 1,32'd5,0,12'h000);
        tbl[6]  = mk(1,0,4'h5,0,4'h0,4'h0,12'h000, 1,32'd5,0,12'h000);
        tbl[7]  = mk(1,0,4'h6,0,4'h0,4'h0,12'h000, 1,32'h0,0,12'h000);
        tbl[8]  = mk(0,0,4'h0,0,4'h1,4'h0,12'h000, 0,0,0,12'h000);
        tbl[9]  = mk(1,0,4'h2,0,4'h0,4'h0,12'h000, 1,32'h40,1,12'h000);
        tbl[10] = mk(1,1,4'h2,32'h40,4'h0,4'h0,12'h000, 0,0,1,12'h000);
        tbl[11] = mk(0,0,4'h0,0,4'h0,4'h0,12'h000, 0,0,0,12'h000);
        tbl[12] = mk(0,0,4'h0,0,4'h1,4'h0,12'h000, 0,0,0,12'h000);
        tbl[13] = mk(1,1,4'h2,32'h40,4'h1,4'h0,12'h000, 0,0,1,12'h000);
        tbl[14] = mk(1,0,4'h2,0,4'h0,4'h0,12'h000, 1,32'h40,1,12'h000);
        tbl[15] = mk(1,1,4'h2,32'h40,4'h0,4'h0,12'h000, 0,0,1,12'h000);
        tbl[16] = mk(0,0,4'h0,0,4'h0,4'h0,12'h000, 0,0,0,12'h000);
        tbl[17] = mk(0,0,4'h0,0,4'h0,4'h0,12'h080, 0,0,0,12'h000);
        tbl[18] = mk(1,0,4'hA,0,4'h0,4'h0,12'h080, 1,32'h12,1,12'h000);
        tbl[19] = mk(1,1,4'hA,32'h10,4'h0,4'h0,12'h080, 0,0,1,12'h000);
        tbl[20] = mk(1,0,4'hA,0,4'h0,4'h0,12'h080, 1,32'h02,0,12'h000);
        tbl[21] = mk(0,0,4'h0,0,4'h0,4'h0,12'h080, 0,0,0,12'h000);
        tbl[22] = mk(1,1,4'hF,32'h5,4'h0,4'h0,12'h080, 0,0,0,12'hA00);
        tbl[23] = mk(1,0,4'hF,0,4'h0,4'h0,12'h080, 1,32'h5,0,12'hA00);
        tbl[24] = mk(1,1,4'h4,32'hDEAD,4'h2,4'h2,12'h080, 0,0,0,12'hA00);
        tbl[25] = mk(1,0,4'h4,0,4'h0,4'h0,12'h080, 1,32'd1,0,12'hA00);
        tbl[26] = mk(1,0,4'h5,0,4'h0,4'h0,12'h080, 1,32'd6,0,12'hA00);
        tbl[27] = mk(1,1,4'h5,32'h0,4'h0,4'h0,12'h080, 0,0,0,12'hA00);
        tbl[28] = mk(1,0,4'h5,0,4'h0,4'h0,12'h080, 1,32'd0,0,12'hA00);
        tbl[29] = mk(1,1,4'hF,32'hFFFF_FFF2,4'h0,4'h0,12'h080, 0,0,0,12'h400);
        tbl[30] = mk(1,0,4'hF,0,4'h0,4'h0,12'h080, 1,32'd2,0,12'h400);
        tbl[31] = mk(1,0,4'h0,0,4'h0,4'h0,12'h080, 1,32'd3,0,12'h400);
        tbl[32] = mk(1,0,4'h1,0,4'h0,4'h0,12'h080, 1,32'd0,0,12'h400);

        // reset with random inputs, then a read interrupted by reset
        rst_n = 1'b0;
        det = 4'($urandom); cor = 4'($urandom); brk = 12'($urandom);
        req = 1'b1; we = 1'($urandom); addr = 4'($urandom); wdata = $urandom;
        s_det = 3'($urandom); s_cor = 3'($urandom); s_brk = 9'($urandom);
        s_req = 1'b1; s_we = 1'b0; s_addr = 4'($urandom); s_wdata = $urandom;
        step(); step();
        check("reset rvalid", 32'(rv), 0);
        check("reset rdata", rd, 0);
        check("reset irq", 32'(irq), 0);
        check("reset set_broken", 32'(set_b), 0);
        check("reset sat rvalid", 32'(s_rv), 0);
        det = '0; cor = '0; brk = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        s_det = '0; s_cor = '0; s_brk = '0; s_idle();
        rst_n = 1'b1;
        step();
        req = 1'b1; addr = 4'h0;
        #2 rst_n = 1'b0;
        step();
        check("mid-read reset rvalid", 32'(rv), 0);
        check("mid-read reset rdata", rd, 0);
        req = 1'b0;
        rst_n = 1'b1;
        step();
        check("post-reset rvalid", 32'(rv), 0);

        foreach (tbl[i]) begin
            req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata;
            det = tbl[i].det; cor = tbl[i].cor; brk = tbl[i].brk;
            step();
            check($sformatf("vec%0d rvalid", i), 32'(rv), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) check($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d irq", i), 32'(irq), 32'(tbl[i].exp_irq));
            check($sformatf("vec%0d set_broken", i), 32'(set_b), 32'(tbl[i].exp_set));
        end
        req = 1'b0; we = 1'b0;

        // 2-bit counters: saturation and clear coincident with an event
        s_det = 3'b001; s_cor = 3'b001;
        repeat (6) step();
        s_det = '0; s_cor = '0;
        s_read(4'h0, 32'd3, "sat det saturated");
        s_req = 1'b1; s_we = 1'b1; s_addr = 4'h0; s_wdata = 32'h0;
        s_det = 3'b001; s_cor = 3'b001;
        step();
        s_idle(); s_det = '0; s_cor = '0;
        s_read(4'h0, 32'd1, "sat clear+event");
        s_read(4'h1, 32'd3, "sat cor held");
        s_det = 3'b001; s_cor = 3'b001;
        repeat (3) step();
        s_det = '0; s_cor = '0;
        s_read(4'h0, 32'd3, "sat det again");
        s_req = 1'b1; s_we = 1'b1; s_addr = 4'h0;
        step();
        s_idle();
        s_read(4'h0, 32'd0, "sat clear no event");
        s_read(4'hC, 32'd0, "out-of-range read");
        s_req = 1'b1; s_we = 1'b1; s_addr = 4'hF; s_wdata = 32'h7;
        step();
        s_idle();
        check("out-of-range write ignored", 32'(s_set), 0);
        s_req = 1'b1; s_we = 1'b1; s_addr = 4'hB; s_wdata = 32'h7;
        step();
        s_idle();
        check("sat unit2 force", 32'(s_set), 32'h1C0);
        check("sat irq quiet", 32'(s_irq), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
